magnitude_compare_sequencer: RTL



---
 rtl/magnitude_compare_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/magnitude_compare_sequencer.sv
// Sequential N-bit magnitude comparator: WIDTH_IN bits per clock over SLICES slices, 74x85-style cascade.
// Define MAGNITUDE_COMPARE_EARLY_EXIT_EN for MSB-first processing that stops at the first unequal slice.
module magnitude_compare_sequencer #(
  parameter int WIDTH_IN   = 4,
  parameter int SLICES     = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                         Clk,
  input  logic                         Clear_bar,
  input  logic                         Start,
  input  logic [WIDTH_IN*SLICES-1:0]   A,
  input  logic [WIDTH_IN*SLICES-1:0]   B,
  input  logic                         ALess_in,
  input  logic                         Equal_in,
  input  logic                         AGreater_in,
  output logic                         Busy,
  output logic                         Done,
  output logic                         ALess_out,
  output logic                         Equal_out,
  output logic                         AGreater_out
);

  // state   | meaning
  // IDLE    | waiting for Start; the accepting edge already compares the first slice
  // COMPARE | walking the remaining slices of the latched operands

  localparam int N  = WIDTH_IN * SLICES;
  localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

  // Outputs are plain registers; the delay parameters exist only for interface compatibility.
  localparam int unused_delay_sum = DELAY_RISE + DELAY_FALL;

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [N-1:0]    a_r, b_r;
  logic [2:0]      casc_r;      // {L, E, G}

  logic [N-1:0]        op_a, op_b;
  logic [2:0]          cin, eq_rule, nxt;
  logic [IW-1:0]       sel;
  logic [WIDTH_IN-1:0] sa, sb;
  logic                last;

  always_comb begin
    op_a = a_r;
    op_b = b_r;
    cin  = casc_r;
    if (state == IDLE) begin
      op_a = A;
      op_b = B;
      cin  = {ALess_in, Equal_in, AGreater_in};
    end
`ifdef MAGNITUDE_COMPARE_EARLY_EXIT_EN
    sel = (state == IDLE) ? LAST : LAST - IW'(1) - idx;
`else
    sel = (state == IDLE) ? '0 : idx + IW'(1);
`endif
    sa = WIDTH_IN'(op_a >> (int'(sel) * WIDTH_IN));
    sb = WIDTH_IN'(op_b >> (int'(sel) * WIDTH_IN));
    eq_rule = {!cin[1] & !cin[0], cin[1], !cin[1] & !cin[2]};
    if (sa > sb)
      nxt = 3'b001;
    else if (sa < sb)
      nxt = 3'b100;
`ifdef MAGNITUDE_COMPARE_EARLY_EXIT_EN
    else
      nxt = eq_rule;
    last = (sa != sb) || (sel == '0);
`else
    // Abnormal cascade patterns are decoded once at the lowest slice; higher equal slices pass through.
    else if (state == IDLE)
      nxt = eq_rule;
    else
      nxt = cin;
    last = (sel == LAST);
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Clear_bar) begin
      state        <= IDLE;
      idx          <= '0;
      a_r          <= '0;
      b_r          <= '0;
      casc_r       <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      ALess_out    <= 1'b0;
      Equal_out    <= 1'b0;
      AGreater_out <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            a_r <= A;
            b_r <= B;
            idx <= '0;
`ifdef MAGNITUDE_COMPARE_EARLY_EXIT_EN
            casc_r <= {ALess_in, Equal_in, AGreater_in};
`else
            casc_r <= nxt;
`endif
            if (last) begin
              {ALess_out, Equal_out, AGreater_out} <= nxt;
              Done <= 1'b1;
            end else begin
              Busy  <= 1'b1;
              state <= COMPARE;
            end
          end
        end
        COMPARE: begin
          if (last) begin
            {ALess_out, Equal_out, AGreater_out} <= nxt;
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx + IW'(1);
`ifndef MAGNITUDE_COMPARE_EARLY_EXIT_EN
            casc_r <= nxt;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
